nanov_uart_tx: RTL



---
 rtl/nanov_uart_tx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/nanov_uart_tx.sv
// rtl/nanov_uart_tx.sv - store-strobe byte FIFO draining onto an 8N1 UART line
module nanov_uart_tx #(
  parameter int unsigned CLK_DIV = 16,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] store_data,
  input  logic        store_strobe,
  output logic        uart_tx,
  output logic        tx_busy,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic        overflow
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);
  localparam logic [15:0] TMAX = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e             state_q, state_d;
  logic [15:0]        timer_q, timer_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               ovf_q, ovf_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [7:0]         mem_q [DEPTH];

  logic pop, push_ok, timer_done;
  logic unused_store_hi;

  assign unused_store_hi = ^store_data[31:8];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign uart_tx    = tx_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign overflow   = ovf_q;
  assign timer_done = (timer_q == TMAX);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          timer_d = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (timer_done) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_DATA: begin
        if (timer_done) begin
          timer_d = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        if (timer_done) begin
          timer_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
    endcase

    if (pop) shift_d = mem_q[rd_ptr_q];

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    push_ok  = store_strobe && ((count_q < DEPTH_C) || pop);
    ovf_d    = ovf_q | (store_strobe & ~push_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= store_data[7:0];
  end

endmodule
